// File: rtl/complex_nr_acc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// complex_nr_acc
//
// Purpose:
//   Consumer end of the complex multiplier result interface. Accepts up to
//   ACC_LEN complex products over a valid/ready handshake and sums the real
//   and imaginary parts separately (a complex dot product). The finished sum,
//   with the number of products in it, is presented on a second valid/ready
//   port. A sum can be closed early with acc_flush.
//
// Ports:
//   clk        in   1             clock, rising edge
//   sw_rst     in   1             synchronous active-high reset
//   res_val    in   1             upstream product valid
//   res_ready  out  1             block can accept a product this cycle
//   result_re  in   2*DATA_WIDTH  product real part, two's complement
//   result_im  in   2*DATA_WIDTH  product imaginary part, two's complement
//   acc_flush  in   1             close the current sum early
//   sum_val    out  1             sum_re/sum_im/sum_cnt valid
//   sum_ready  in   1             downstream accepts the sum
//   sum_re     out  ACC_WIDTH     accumulated real part, two's complement
//   sum_im     out  ACC_WIDTH     accumulated imaginary part, two's complement
//   sum_cnt    out  CNT_WIDTH     number of products in the presented sum
// -----------------------------------------------------------------------------
module complex_nr_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_LEN    = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + 2,
  parameter int CNT_WIDTH  = $clog2(ACC_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    sw_rst,
  input  logic                    res_val,
  output logic                    res_ready,
  input  logic [2*DATA_WIDTH-1:0] result_re,
  input  logic [2*DATA_WIDTH-1:0] result_im,
  input  logic                    acc_flush,
  output logic                    sum_val,
  input  logic                    sum_ready,
  output logic [ACC_WIDTH-1:0]    sum_re,
  output logic [ACC_WIDTH-1:0]    sum_im,
  output logic [CNT_WIDTH-1:0]    sum_cnt
);

  localparam int PROD_WIDTH = 2*DATA_WIDTH;
  localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

  // Count value at which the next accept completes a full sum.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_e;

  // Sign-extend a product to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] sext_prod(input logic [PROD_WIDTH-1:0] p);
    sext_prod = {{EXT_WIDTH{p[PROD_WIDTH-1]}}, p};
  endfunction

  state_e                 state_q,   state_d;
  logic [ACC_WIDTH-1:0]   acc_re_q,  acc_re_d;
  logic [ACC_WIDTH-1:0]   acc_im_q,  acc_im_d;
  logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
  logic                   sum_val_q, sum_val_d;
  logic [ACC_WIDTH-1:0]   sum_re_q,  sum_re_d;
  logic [ACC_WIDTH-1:0]   sum_im_q,  sum_im_d;
  logic [CNT_WIDTH-1:0]   sum_cnt_q, sum_cnt_d;

  logic                   accept;
  logic                   close_sum;
  logic [ACC_WIDTH-1:0]   acc_re_add;
  logic [ACC_WIDTH-1:0]   acc_im_add;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  // Ready is a pure decode of the registered state; it never looks at
  // res_val, so the upstream block cannot form a combinational loop with us.
  assign res_ready = (state_q == ST_ACCUM) && !sw_rst;
  assign accept    = res_val && res_ready;

  assign acc_re_add = acc_re_q + sext_prod(result_re);
  assign acc_im_add = acc_im_q + sext_prod(result_im);
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);

  // A sum closes when the last slot is filled, or on a flush that has at
  // least one product to report (already held, or arriving this cycle).
  assign close_sum = (state_q == ST_ACCUM) &&
                     ((accept && (cnt_q == LAST_CNT)) ||
                      (acc_flush && ((cnt_q != '0) || accept)));

  // Next-state, accumulator and output-register computation.
  always_comb begin
    state_d   = state_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    cnt_d     = cnt_q;
    sum_val_d = sum_val_q;
    sum_re_d  = sum_re_q;
    sum_im_d  = sum_im_q;
    sum_cnt_d = sum_cnt_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_re_d = acc_re_add;
          acc_im_d = acc_im_add;
          cnt_d    = cnt_inc;
        end else begin
          acc_re_d = acc_re_q;
          acc_im_d = acc_im_q;
          cnt_d    = cnt_q;
        end

        // The product accepted in the closing cycle belongs to this sum,
        // so load from the post-add values when there is one.
        if (close_sum) begin
          state_d   = ST_OUTPUT;
          sum_val_d = 1'b1;
          sum_re_d  = accept ? acc_re_add : acc_re_q;
          sum_im_d  = accept ? acc_im_add : acc_im_q;
          sum_cnt_d = accept ? cnt_inc    : cnt_q;
        end else begin
          state_d   = ST_ACCUM;
          sum_val_d = 1'b0;
        end
      end

      ST_OUTPUT: begin
        // Outputs hold until the handshake; flush and res_val are ignored.
        // sum_re/sum_im keep their last value after the handshake.
        if (sum_ready) begin
          state_d   = ST_ACCUM;
          acc_re_d  = '0;
          acc_im_d  = '0;
          cnt_d     = '0;
          sum_val_d = 1'b0;
        end else begin
          state_d   = ST_OUTPUT;
          sum_val_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_ACCUM;
        acc_re_d  = '0;
        acc_im_d  = '0;
        cnt_d     = '0;
        sum_val_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q   <= ST_ACCUM;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      cnt_q     <= '0;
      sum_val_q <= 1'b0;
      sum_re_q  <= '0;
      sum_im_q  <= '0;
      sum_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      cnt_q     <= cnt_d;
      sum_val_q <= sum_val_d;
      sum_re_q  <= sum_re_d;
      sum_im_q  <= sum_im_d;
      sum_cnt_q <= sum_cnt_d;
    end
  end

  assign sum_val = sum_val_q;
  assign sum_re  = sum_re_q;
  assign sum_im  = sum_im_q;
  assign sum_cnt = sum_cnt_q;

endmodule
